// File: rtl/uart_rx_if.sv
// Serial receiver bus: line/tick inputs plus received byte, strobe and status.
// slave = receiver side, master = line driver / byte consumer side.
interface uart_rx_if;
   logic       sample_tick;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       parity_err;
   logic       frame_err;
   logic       busy;

   modport slave (
      input  sample_tick, rx,
      output data_out, valid, parity_err, frame_err, busy
   );

   modport master (
      output sample_tick, rx,
      input  data_out, valid, parity_err, frame_err, busy
   );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 11-bit frames (start, 8 data LSB first, even parity, stop),
// oversampled by an external sample_tick. Returns to IDLE at mid-stop bit so
// back-to-back frames are accepted.
// Optional feature macro: UART_RX_PARITY_CHECK_EN (parity_err checked; else tied 0).
module uart_rx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic      clk,
   input  logic      rst,
   uart_rx_if.slave  bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;

   state_t          state, state_n;
   logic [1:0]      sync;
   logic            rx_s;
   logic [TW-1:0]   tcnt;
   logic [2:0]      bcnt;
   logic [7:0]      shreg;
   logic [7:0]      data_out_r;
   logic            valid_r;
   logic            frame_err_r;
   logic            parity_err_r;

   logic tcnt_clr, tcnt_inc, bcnt_clr, shift, par_ld, out_ld;
   logic at_mid, at_last;

   assign rx_s    = sync[1];
   assign at_mid  = bus.sample_tick && (tcnt == MID);
   assign at_last = bus.sample_tick && (tcnt == LAST);

   // Two-flop synchronizer for the asynchronous serial line, idles high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], bus.rx};
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Next-state and datapath strobes; every sample point is one tick.
   always_comb begin
      state_n  = state;
      tcnt_clr = 1'b0;
      tcnt_inc = 1'b0;
      bcnt_clr = 1'b0;
      shift    = 1'b0;
      par_ld   = 1'b0;
      out_ld   = 1'b0;
      unique case (state)
         IDLE: begin
            tcnt_clr = 1'b1;
            if (!rx_s) state_n = START;
         end
         START: begin
            if (at_mid) begin
               tcnt_clr = 1'b1;
               bcnt_clr = 1'b1;
               // A line back high at mid start bit was only a glitch.
               state_n  = rx_s ? IDLE : DATA;
            end else tcnt_inc = bus.sample_tick;
         end
         DATA: begin
            if (at_last) begin
               tcnt_clr = 1'b1;
               shift    = 1'b1;
               if (bcnt == 3'd7) state_n = PARITY;
            end else tcnt_inc = bus.sample_tick;
         end
         PARITY: begin
            if (at_last) begin
               tcnt_clr = 1'b1;
               par_ld   = 1'b1;
               state_n  = STOP;
            end else tcnt_inc = bus.sample_tick;
         end
         STOP: begin
            if (at_last) begin
               tcnt_clr = 1'b1;
               out_ld   = 1'b1;
               state_n  = rx_s ? IDLE : BREAK;
            end else tcnt_inc = bus.sample_tick;
         end
         BREAK: begin
            // Hold off until the line is released so a stuck-low line
            // does not look like a stream of start bits.
            tcnt_clr = 1'b1;
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // Tick and bit counters plus the LSB-first shift register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tcnt  <= '0;
         bcnt  <= '0;
         shreg <= '0;
      end else begin
         if (tcnt_clr)      tcnt <= '0;
         else if (tcnt_inc) tcnt <= tcnt + 1'b1;
         if (bcnt_clr)      bcnt <= '0;
         else if (shift)    bcnt <= bcnt + 1'b1;
         if (shift)         shreg <= {rx_s, shreg[7:1]};
      end
   end

   // Output byte, one-cycle valid and framing flag, loaded at the stop sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_out_r  <= '0;
         valid_r     <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         valid_r <= out_ld;
         if (out_ld) begin
            data_out_r  <= shreg;
            frame_err_r <= ~rx_s;
         end
      end
   end

`ifdef UART_RX_PARITY_CHECK_EN
   logic par_bit;

   // Even parity: capture the parity bit, flag a mismatch with valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         par_bit      <= 1'b0;
         parity_err_r <= 1'b0;
      end else begin
         if (par_ld) par_bit <= rx_s;
         if (out_ld) parity_err_r <= (par_bit != ^shreg);
      end
   end
`else
   // The parity slot is still timed by the FSM; its value is discarded.
   assign parity_err_r = 1'b0;
   logic unused_par_ld;
   assign unused_par_ld = par_ld;
`endif

   assign bus.data_out   = data_out_r;
   assign bus.valid      = valid_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.parity_err = parity_err_r;
   assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE=16, one sample_tick every 4 clk,
// so one bit is 64 clk. A negedge monitor logs every valid cycle.
module tb_uart_rx;
   localparam int BITCLK = 64;
`ifdef UART_RX_PARITY_CHECK_EN
   localparam logic EXP_PE = 1'b1;
`else
   localparam logic EXP_PE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_rx_if bus ();

   int n_tests = 0;
   int n_fail  = 0;
   int vcount  = 0;
   logic [7:0] cap_data [0:63];
   logic       cap_pe   [0:63];
   logic       cap_fe   [0:63];

   uart_rx #(.OVERSAMPLE(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // Tick generator: one pulse every 4 clk, driven away from the active edge.
   initial begin
      int tc = 0;
      bus.sample_tick = 1'b0;
      forever begin
         @(negedge clk);
         tc = (tc + 1) % 4;
         bus.sample_tick = (tc == 0);
      end
   end

   // Valid monitor: one log entry per clk that valid is high.
   always @(negedge clk) begin
      if (bus.valid === 1'b1 && vcount < 64) begin
         cap_data[vcount] = bus.data_out;
         cap_pe[vcount]   = bus.parity_err;
         cap_fe[vcount]   = bus.frame_err;
         vcount = vcount + 1;
      end
   end

   task automatic send_bit(input logic b);
      bus.rx = b;
      repeat (BITCLK) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      send_bit(par);
      send_bit(stop);
   endtask

   task automatic test_reset();
      bus.rx = 1'b1;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h exp 00", bus.data_out); end
      n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.valid); end
      n_tests++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_pe got %b exp 0", bus.parity_err); end
      n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_fe got %b exp 0", bus.frame_err); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
   endtask

   task automatic test_good_frame();
      int v0 = vcount;
      send_frame(8'hA5, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL good_valid_cnt got %0d exp 1", vcount - v0); end
      n_tests++; if (bus.data_out !== 8'hA5) begin n_fail++; $display("FAIL good_data got %h exp a5", bus.data_out); end
      n_tests++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL good_pe got %b exp 0", bus.parity_err); end
      n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL good_fe got %b exp 0", bus.frame_err); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL good_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_bad_parity();
      int v0 = vcount;
      send_frame(8'h3C, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL par_valid_cnt got %0d exp 1", vcount - v0); end
      n_tests++; if (bus.data_out !== 8'h3C) begin n_fail++; $display("FAIL par_data got %h exp 3c", bus.data_out); end
      n_tests++; if (bus.parity_err !== EXP_PE) begin n_fail++; $display("FAIL par_pe got %b exp %b", bus.parity_err, EXP_PE); end
      n_tests++; if (bus.frame_err !== 1'b0) begin n_fail++; $display("FAIL par_fe got %b exp 0", bus.frame_err); end
   endtask

   task automatic test_frame_err();
      int v0 = vcount;
      send_frame(8'h81, 1'b0, 1'b0);
      repeat (3 * BITCLK) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL fe_valid_cnt got %0d exp 1", vcount - v0); end
      n_tests++; if (bus.data_out !== 8'h81) begin n_fail++; $display("FAIL fe_data got %h exp 81", bus.data_out); end
      n_tests++; if (bus.frame_err !== 1'b1) begin n_fail++; $display("FAIL fe_flag got %b exp 1", bus.frame_err); end
      n_tests++; if (bus.parity_err !== 1'b0) begin n_fail++; $display("FAIL fe_pe got %b exp 0", bus.parity_err); end
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL fe_busy_break got %b exp 1", bus.busy); end
      @(negedge clk);
      bus.rx = 1'b1;
      repeat (10) @(negedge clk);
      #1;
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL fe_busy_release got %b exp 0", bus.busy); end
      repeat (2 * BITCLK) @(negedge clk);
      n_tests++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL fe_no_second got %0d exp 1", vcount - v0); end
   endtask

   task automatic test_glitch();
      int v0 = vcount;
      bus.rx = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start got %b exp 1", bus.busy); end
      repeat (6) @(negedge clk);
      bus.rx = 1'b1;
      repeat (2 * BITCLK) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL glitch_valid_cnt got %0d exp 0", vcount - v0); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b exp 0", bus.busy); end
   endtask

   task automatic test_back_to_back();
      int v0 = vcount;
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 2) begin n_fail++; $display("FAIL b2b_valid_cnt got %0d exp 2", vcount - v0); end
      if (vcount - v0 >= 2) begin
         n_tests++; if (cap_data[v0] !== 8'h00) begin n_fail++; $display("FAIL b2b_data0 got %h exp 00", cap_data[v0]); end
         n_tests++; if (cap_data[v0+1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_data1 got %h exp ff", cap_data[v0+1]); end
         n_tests++; if ({cap_pe[v0], cap_fe[v0], cap_pe[v0+1], cap_fe[v0+1]} !== 4'b0000) begin
            n_fail++; $display("FAIL b2b_flags got %b exp 0000", {cap_pe[v0], cap_fe[v0], cap_pe[v0+1], cap_fe[v0+1]});
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int v0 = vcount;
      logic [7:0] d = 8'h55;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(d[i]);
      bus.rx = d[4];
      repeat (BITCLK / 2) @(negedge clk);
      rst = 1'b1;
      #1;
      n_tests++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h exp 00", bus.data_out); end
      n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", bus.busy); end
      n_tests++; if (bus.valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", bus.valid); end
      bus.rx = 1'b1;
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (BITCLK) @(negedge clk);
      n_tests++; if (vcount - v0 !== 0) begin n_fail++; $display("FAIL rmid_no_valid got %0d exp 0", vcount - v0); end
      send_frame(8'h5A, 1'b0, 1'b1);
      repeat (4) @(negedge clk);
      #1;
      n_tests++; if (vcount - v0 !== 1) begin n_fail++; $display("FAIL rmid_after_cnt got %0d exp 1", vcount - v0); end
      n_tests++; if (bus.data_out !== 8'h5A) begin n_fail++; $display("FAIL rmid_after_data got %h exp 5a", bus.data_out); end
   endtask

   initial begin
      bus.rx = 1'b1;
      test_reset();
      test_good_frame();
      test_bad_parity();
      test_frame_err();
      test_glitch();
      test_back_to_back();
      test_reset_mid_frame();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
